// File: rtl/hazard_pkg.sv
// Shared types, defaults and helpers for the
// forwarding / interlock controller.
package hazard_pkg;

    localparam int DEF_NUM_SRC   = 2;
    localparam int DEF_REG_AW    = 5;
    localparam int DEF_FWD_DEPTH = 2;
    localparam int DEF_LAT_W     = 2;
    localparam int DEF_SEL_W     = $clog2(DEF_FWD_DEPTH + 1);

    typedef logic [DEF_SEL_W-1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_NONE = '0;

    typedef struct packed {
        logic                  valid;
        logic [DEF_REG_AW-1:0] rd;
        fwd_sel_t              lat;
    } sb_rec_t;

    // 0 means "forwardable from MEM", anything past WB saturates.
    function automatic int clamp_lat(int lat, int depth);
        if (lat < 1) begin
            return 1;
        end
        if (lat > depth) begin
            return depth;
        end
        return lat;
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-side request bundle and EX-side forwarding
// results for fwd_hazard_ctrl.
interface fwd_hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    parameter int REG_AW  = DEF_REG_AW,
    parameter int LAT_W   = DEF_LAT_W,
    parameter int SEL_W   = DEF_SEL_W
) ();

    logic                      id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_rs_addr;
    logic [NUM_SRC-1:0]        id_rs_used;
    logic [REG_AW-1:0]         id_rd_addr;
    logic                      id_rd_we;
    logic [LAT_W-1:0]          id_lat;
    logic                      pipe_hold;
    logic                      flush;
    logic                      stall;
    logic [NUM_SRC-1:0]        id_wb_bypass;
    logic                      ex_valid;
    logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel;

    modport master (
        output id_valid, id_rs_addr, id_rs_used,
        output id_rd_addr, id_rd_we, id_lat,
        output pipe_hold, flush,
        input  stall, id_wb_bypass, ex_valid, ex_fwd_sel
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rs_used,
        input  id_rd_addr, id_rd_we, id_lat,
        input  pipe_hold, flush,
        output stall, id_wb_bypass, ex_valid, ex_fwd_sel
    );

endinterface

// File: rtl/fwd_hazard_ctrl_fwd_match.sv
// Per-operand priority search over the in-flight
// destination records: forward select, ready, WB bypass.
module fwd_match
    import hazard_pkg::*;
#(
    parameter int REG_AW    = DEF_REG_AW,
    parameter int FWD_DEPTH = DEF_FWD_DEPTH,
    parameter int SEL_W     = DEF_SEL_W
) (
    input  logic [REG_AW-1:0]                rs_addr,
    input  logic                             rs_used,
    input  logic [FWD_DEPTH:0]               rec_valid,
    input  logic [(FWD_DEPTH+1)*REG_AW-1:0]  rec_rd,
    input  logic [(FWD_DEPTH+1)*SEL_W-1:0]   rec_lat,
    output logic [SEL_W-1:0]                 sel,
    output logic                             ready,
    output logic                             wb_bypass
);

    logic hit;

    // Youngest matching record wins; its next-cycle stage decides.
    always_comb begin
        sel       = SEL_W'(FWD_NONE);
        ready     = 1'b1;
        wb_bypass = 1'b0;
        hit       = 1'b0;
        for (int k = 0; k <= FWD_DEPTH; k++) begin
            if (!hit && rs_used && rs_addr != '0 && rec_valid[k] &&
                rec_rd[k*REG_AW +: REG_AW] == rs_addr) begin
                hit = 1'b1;
                if (k == FWD_DEPTH) begin
                    wb_bypass = 1'b1;
                end else if (k + 1 >= int'(rec_lat[k*SEL_W +: SEL_W])) begin
                    sel = SEL_W'(k + 1);
                end else begin
                    ready = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / load-use interlock controller.
// Optional stall_cnt perf counter: define HAZARD_PERF_EN.
module fwd_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter  int NUM_SRC   = DEF_NUM_SRC,
    parameter  int REG_AW    = DEF_REG_AW,
    parameter  int FWD_DEPTH = DEF_FWD_DEPTH,
    parameter  int LAT_W     = DEF_LAT_W,
    localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic        clk,
    input  logic        rst,
`ifdef HAZARD_PERF_EN
    output logic [31:0] stall_cnt,
`endif
    fwd_hazard_ctrl_if.slave bus
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic [SEL_W-1:0]  lat;
    } rec_t;

    rec_t rec_q [FWD_DEPTH+1];
    rec_t id_rec;

    logic [FWD_DEPTH:0]              rec_vld;
    logic [(FWD_DEPTH+1)*REG_AW-1:0] rec_rd;
    logic [(FWD_DEPTH+1)*SEL_W-1:0]  rec_lat;

    logic [NUM_SRC*SEL_W-1:0] src_sel;
    logic [NUM_SRC-1:0]       src_rdy;
    logic [NUM_SRC-1:0]       src_byp;
    logic [NUM_SRC*SEL_W-1:0] nxt_sel;
    logic                     stall;
    logic                     issue;
    logic                     ex_valid_q;
    logic [NUM_SRC*SEL_W-1:0] ex_sel_q;

    for (genvar k = 0; k <= FWD_DEPTH; k++) begin : g_flat
        assign rec_vld[k]                  = rec_q[k].valid;
        assign rec_rd[k*REG_AW +: REG_AW]  = rec_q[k].rd;
        assign rec_lat[k*SEL_W +: SEL_W]   = rec_q[k].lat;
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_match #(
            .REG_AW    (REG_AW),
            .FWD_DEPTH (FWD_DEPTH),
            .SEL_W     (SEL_W)
        ) u_match (
            .rs_addr   (bus.id_rs_addr[i*REG_AW +: REG_AW]),
            .rs_used   (bus.id_rs_used[i]),
            .rec_valid (rec_vld),
            .rec_rd    (rec_rd),
            .rec_lat   (rec_lat),
            .sel       (src_sel[i*SEL_W +: SEL_W]),
            .ready     (src_rdy[i]),
            .wb_bypass (src_byp[i])
        );
    end

    assign stall   = !rst && bus.id_valid && !(&src_rdy);
    assign issue   = bus.id_valid && !stall;
    assign nxt_sel = issue ? src_sel : '0;

    // Record entering EX when ID issues; bubble otherwise.
    always_comb begin
        id_rec       = '0;
        id_rec.valid = issue && bus.id_rd_we && bus.id_rd_addr != '0;
        id_rec.rd    = bus.id_rd_addr;
        id_rec.lat   = SEL_W'(clamp_lat(int'(bus.id_lat), FWD_DEPTH));
    end

    // Scoreboard shift and EX-side registered selects.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= FWD_DEPTH; k++) begin
                rec_q[k] <= '0;
            end
            ex_valid_q <= 1'b0;
            ex_sel_q   <= '0;
        end else if (bus.flush) begin
            rec_q[0] <= '0;
            rec_q[1] <= '0;
            for (int k = 1; k < FWD_DEPTH; k++) begin
                rec_q[k+1] <= rec_q[k];
            end
            ex_valid_q <= 1'b0;
            ex_sel_q   <= '0;
        end else if (!bus.pipe_hold) begin
            rec_q[0] <= id_rec;
            for (int k = 0; k < FWD_DEPTH; k++) begin
                rec_q[k+1] <= rec_q[k];
            end
            ex_valid_q <= issue;
            ex_sel_q   <= nxt_sel;
        end
    end

    assign bus.stall        = stall;
    assign bus.id_wb_bypass = rst ? '0 : src_byp;
    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_fwd_sel   = ex_sel_q;

`ifdef HAZARD_PERF_EN
    // Saturating count of cycles lost to interlock.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && !bus.pipe_hold && !bus.flush &&
                     stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: directed
// hazard scenarios followed by a random stretch.
module tb_fwd_hazard_ctrl;
    import hazard_pkg::*;

    localparam int NS = 2;
    localparam int AW = 5;
    localparam int FD = 2;
    localparam int LW = 2;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fwd_hazard_ctrl_if #(
        .NUM_SRC (NS),
        .REG_AW  (AW),
        .LAT_W   (LW),
        .SEL_W   (SW)
    ) bus ();

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
`endif

    fwd_hazard_ctrl #(
        .NUM_SRC   (NS),
        .REG_AW    (AW),
        .FWD_DEPTH (FD),
        .LAT_W     (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef HAZARD_PERF_EN
        .stall_cnt (stall_cnt),
`endif
        .bus       (bus)
    );

    typedef struct {
        int rd;
        int lat;
        int pos;
    } ent_t;

    typedef struct {
        bit          v;
        int          s0;
        int          s1;
        logic [31:0] cnt;
    } exp_t;

    ent_t        inflight[$];
    exp_t        sb[$];
    bit          m_ex_v;
    int          m_sel[2];
    logic [31:0] m_cnt;
    int          n_vec;
    int          n_bad;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic step(bit v, int a0, int a1, bit [1:0] used,
                        int rd, bit we, int lat,
                        bit hold = 0, bit fl = 0, bit r = 0);
        int   sel[2];
        bit   rdy[2];
        bit   byp[2];
        bit   st;
        int   addr;
        int   best;
        int   blat;
        int   cl;
        exp_t e;
        ent_t ne;
        ent_t nq[$];
        @(negedge clk);
        rst              = r;
        bus.id_valid     = v;
        bus.id_rs_addr   = {AW'(a1), AW'(a0)};
        bus.id_rs_used   = used;
        bus.id_rd_addr   = AW'(rd);
        bus.id_rd_we     = we;
        bus.id_lat       = LW'(lat);
        bus.pipe_hold    = hold;
        bus.flush        = fl;
        #1;
        for (int i = 0; i < 2; i++) begin
            addr   = (i == 0) ? a0 : a1;
            best   = -1;
            blat   = 1;
            sel[i] = 0;
            rdy[i] = 1;
            byp[i] = 0;
            foreach (inflight[j]) begin
                if (used[i] && addr != 0 && inflight[j].rd == addr &&
                    (best < 0 || inflight[j].pos < best)) begin
                    best = inflight[j].pos;
                    blat = inflight[j].lat;
                end
            end
            if (best == FD) byp[i] = 1;
            else if (best >= 0) begin
                if (best + 1 >= blat) sel[i] = best + 1;
                else rdy[i] = 0;
            end
        end
        st = !r && v && !(rdy[0] && rdy[1]);
        chk("stall", 32'(bus.stall), 32'(st));
        chk("wb_bypass0", 32'(bus.id_wb_bypass[0]), 32'(!r && byp[0]));
        chk("wb_bypass1", 32'(bus.id_wb_bypass[1]), 32'(!r && byp[1]));
        if (r) begin
            inflight.delete();
            m_ex_v = 0;
            m_sel  = '{0, 0};
            m_cnt  = 0;
        end else begin
            if (st && !hold && !fl && m_cnt != 32'hFFFF_FFFF) m_cnt++;
            if (fl || !hold) begin
                nq = {};
                foreach (inflight[j]) begin
                    ne = inflight[j];
                    if (!(fl && ne.pos == 0) && ne.pos + 1 <= FD) begin
                        ne.pos++;
                        nq.push_back(ne);
                    end
                end
                inflight = nq;
            end
            if (fl) begin
                m_ex_v = 0;
                m_sel  = '{0, 0};
            end else if (!hold) begin
                cl = (lat == 0) ? 1 : (lat > FD) ? FD : lat;
                if (v && !st && we && rd != 0) begin
                    ne = '{rd: rd, lat: cl, pos: 0};
                    inflight.push_back(ne);
                end
                m_ex_v = v && !st;
                m_sel  = m_ex_v ? sel : '{0, 0};
            end
        end
        e = '{v: m_ex_v, s0: m_sel[0], s1: m_sel[1], cnt: m_cnt};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("ex_valid", 32'(bus.ex_valid), 32'(e.v));
        chk("ex_fwd_sel0", 32'(bus.ex_fwd_sel[0 +: SW]), 32'(e.s0));
        chk("ex_fwd_sel1", 32'(bus.ex_fwd_sel[SW +: SW]), 32'(e.s1));
`ifdef HAZARD_PERF_EN
        chk("stall_cnt", stall_cnt, e.cnt);
`endif
    endtask

    initial begin
        n_vec          = 0;
        n_bad          = 0;
        m_ex_v         = 0;
        m_sel          = '{0, 0};
        m_cnt          = 0;
        bus.id_valid   = 0;
        bus.id_rs_addr = '0;
        bus.id_rs_used = '0;
        bus.id_rd_addr = '0;
        bus.id_rd_we   = 0;
        bus.id_lat     = '0;
        bus.pipe_hold  = 0;
        bus.flush      = 0;

        // reset state
        step(1, 1, 2, 2'b11, 3, 1, 1, 0, 0, 1);
        step(0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 2'b00, 0, 0, 1);

        // ALU x5 then back-to-back use of x5 -> MEM forward
        step(1, 1, 2, 2'b11, 5, 1, 1);
        step(1, 5, 0, 2'b01, 0, 0, 1);

        // load x6 (lat 2) then rs2=x6 -> one bubble, then WB-1 sel 2
        step(1, 1, 0, 2'b01, 6, 1, 2);
        step(1, 0, 6, 2'b10, 0, 0, 1);
        step(1, 0, 6, 2'b10, 0, 0, 1);

        // x7 reaches WB while ID reads it -> regfile bypass
        step(1, 0, 0, 2'b00, 7, 1, 1);
        step(1, 1, 2, 2'b11, 0, 0, 1);
        step(1, 3, 4, 2'b11, 0, 0, 1);
        step(1, 7, 0, 2'b01, 0, 0, 1);

        // two writers of x8 -> youngest; x0 producer never matches
        step(1, 0, 0, 2'b00, 8, 1, 1);
        step(1, 0, 0, 2'b00, 8, 1, 1);
        step(1, 8, 8, 2'b11, 0, 1, 3);
        step(1, 0, 0, 2'b11, 0, 1, 3);

        // lat clamp: 3 behaves as 2, 0 behaves as 1
        step(1, 0, 0, 2'b00, 9, 1, 3);
        step(1, 9, 0, 2'b01, 0, 0, 1);
        step(1, 9, 0, 2'b01, 0, 0, 1);
        step(1, 0, 0, 2'b00, 10, 1, 0);
        step(1, 10, 10, 2'b11, 0, 0, 1);

        // load-use with flush in the same cycle
        step(1, 0, 0, 2'b00, 11, 1, 2);
        step(1, 11, 0, 2'b01, 0, 0, 1, 0, 1);
        step(1, 11, 0, 2'b01, 0, 0, 1);

        // hold during a stall, then release
        step(1, 0, 0, 2'b00, 12, 1, 2);
        for (int h = 0; h < 3; h++) step(1, 12, 0, 2'b01, 0, 0, 1, 1);
        step(1, 12, 0, 2'b01, 0, 0, 1);
        step(1, 12, 0, 2'b01, 0, 0, 1);

        // reset while stalled
        step(1, 0, 0, 2'b00, 13, 1, 2);
        step(1, 0, 13, 2'b10, 0, 0, 1, 0, 0, 1);
        step(1, 0, 13, 2'b10, 0, 0, 1);

        // random traffic over a small register set
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 3)),
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 49) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
